// File: rtl/usb_pkg.sv
// usb_pkg: shared USB line-state constants and bit-stuffing defaults.
package usb_pkg;
    localparam logic USB_J         = 1'b1;
    localparam logic USB_K         = 1'b0;
    localparam int   USB_STUFF_LEN = 6;
endpackage

// File: rtl/nrzi_bit_stuffer.sv
// nrzi_bit_stuffer: tracks runs of data 1s and inserts a 0 after STUFF_LEN of them,
// back-pressuring the source while the stuffed bit goes out.
module nrzi_bit_stuffer
    import usb_pkg::*;
#(
    parameter int STUFF_LEN = USB_STUFF_LEN
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_data,
    input  logic i_valid,
    output logic o_ready,
    output logic o_bit,
    output logic o_bit_valid,
    output logic o_stuff
);
    localparam int CW = $clog2(STUFF_LEN + 1);

    logic [CW-1:0] count, count_n;
    logic          stuff_pend, stuff_pend_n;
    logic          accept;

    assign o_ready     = ~stuff_pend;
    assign accept      = i_valid & ~stuff_pend;
    assign o_bit       = stuff_pend ? 1'b0 : i_data;
    assign o_bit_valid = accept | stuff_pend;
    assign o_stuff     = stuff_pend;

    always_comb begin
        count_n      = '0;
        stuff_pend_n = 1'b0;
        if (accept && i_data) begin
            if (count == CW'(STUFF_LEN - 1))
                stuff_pend_n = 1'b1;
            else
                count_n = count + CW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            count      <= '0;
            stuff_pend <= 1'b0;
        end else begin
            count      <= count_n;
            stuff_pend <= stuff_pend_n;
        end
    end
endmodule

// File: rtl/nrzi_encode.sv
// nrzi_encode: USB-style NRZI transmit encoder with bit stuffing;
// a 0 toggles the line, a 1 holds it, idle returns the line to J.
module nrzi_encode
    import usb_pkg::*;
#(
    parameter int STUFF_LEN = USB_STUFF_LEN
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_data,
    input  logic i_valid,
    output logic o_ready,
    output logic o_nrzi,
    output logic o_valid,
    output logic o_stuff
);
    logic bit_d, bit_v, bit_s;

    nrzi_bit_stuffer #(.STUFF_LEN(STUFF_LEN)) u_stuffer (
        .i_clk      (i_clk),
        .i_rstn     (i_rstn),
        .i_data     (i_data),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .o_bit      (bit_d),
        .o_bit_valid(bit_v),
        .o_stuff    (bit_s)
    );

    // o_nrzi doubles as the line-state register: it always equals the last level driven.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_nrzi  <= USB_J;
            o_valid <= 1'b0;
            o_stuff <= 1'b0;
        end else begin
            o_nrzi  <= bit_v ? (bit_d ? o_nrzi : ~o_nrzi) : USB_J;
            o_valid <= bit_v;
            o_stuff <= bit_s;
        end
    end
endmodule
